// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared state encoding and constants for the fetch controller
// Rev 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } fetch_state_e;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : small prefetch FIFO with push/pop/flush and registered head
// Rev 1.0
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    // Pops on an empty FIFO are ignored so pointers can never desynchronise.
    assign w_pop   = i_pop & (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (i_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!i_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// instr_fetch_ctrl : PC sequencing, prefetch FIFO and redirect/misalign FSM
// Rev 1.0
// ============================================================================
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    input  logic                  out_ready,
    output logic                  misalign_err
);

    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e          r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_misalign;

    logic [EW-1:0]         w_head;
    logic [CW-1:0]         w_count;
    logic                  w_deq;
    logic                  w_enq;
    logic                  w_room;
    logic                  w_misaligned;

    assign instr_addr   = r_pc;
    assign out_valid    = (w_count != '0);
    assign out_pc       = out_valid ? w_head[EW-1:DATA_WIDTH] : '0;
    assign out_instr    = out_valid ? w_head[DATA_WIDTH-1:0] : DATA_WIDTH'(NOP_INSTR);
    assign misalign_err = r_misalign;

    // A full FIFO may still accept a word when the head leaves in the same cycle.
    assign w_deq        = out_valid & out_ready;
    assign w_room       = (w_count < CW'(FIFO_DEPTH)) | w_deq;
    assign w_enq        = (r_state == RUN) & fetch_en & w_room & ~redirect_valid;
    assign w_misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_enq),
        .i_pop   (w_deq),
        .i_flush (redirect_valid),
        .i_data  ({r_pc, instr}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
            if (w_misaligned) begin
                r_state    <= ERR;
                r_misalign <= 1'b1;
            end else begin
                r_state    <= fetch_en ? RUN : IDLE;
                r_misalign <= 1'b0;
            end
        end else begin
            if (w_enq) r_pc <= r_pc + ADDR_WIDTH'(INSTR_BYTES);
            // ERR is left only through an aligned redirect.
            if (r_state != ERR) r_state <= fetch_en ? RUN : IDLE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_ctrl : directed self-checking bench for instr_fetch_ctrl
// Rev 1.0
// ============================================================================
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, rst_n_w;
    logic [31:0] instr_addr, instr, redirect_pc, out_instr, out_pc;
    logic        fetch_en, redirect_valid, out_valid, out_ready, misalign_err;
    logic [31:0] instr_addr_w, instr_w, out_instr_w, out_pc_w;
    logic        fetch_en_w, out_valid_w, misalign_err_w;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign instr   = mem_word(instr_addr);
    assign instr_w = mem_word(instr_addr_w);

    instr_fetch_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .instr_addr(instr_addr), .instr(instr),
        .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .misalign_err(misalign_err)
    );

    instr_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n_w), .instr_addr(instr_addr_w), .instr(instr_w),
        .fetch_en(fetch_en_w), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .out_valid(out_valid_w), .out_instr(out_instr_w), .out_pc(out_pc_w),
        .out_ready(1'b1), .misalign_err(misalign_err_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".instr"}, out_instr, mem_word(pc));
    endtask

    initial begin
        rst_n = 1'b0; rst_n_w = 1'b0;
        fetch_en = 1'b1; fetch_en_w = 1'b0;
        out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();
        chk("rst.valid", {31'b0, out_valid}, 32'd0);
        chk("rst.instr", out_instr, 32'h0000_0013);
        chk("rst.pc", out_pc, 32'h0);
        chk("rst.err", {31'b0, misalign_err}, 32'd0);
        chk("rst.addr", instr_addr, 32'h0);

        // 1: streaming, one per cycle
        rst_n = 1'b1;
        tick();
        chk("t1.first_idle", {31'b0, out_valid}, 32'd0);
        tick();
        for (int k = 0; k < 6; k++) begin
            chk_head("t1", 32'(4 * k));
            if (k < 5) tick();
        end

        // 2: backpressure fills FIFO (head 20, pc stalls at 28)
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk_head("t2.hold", 32'd20);
        chk("t2.pc_stall", instr_addr, 32'd28);
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk_head("t2.drain", 32'(20 + 4 * k));
        end

        // 3: redirect while full
        out_ready = 1'b0;
        tick();
        chk("t3.full_addr", instr_addr, 32'd40);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("t3.bubble", {31'b0, out_valid}, 32'd0);
        chk("t3.addr", instr_addr, 32'h100);
        tick();
        chk_head("t3.target", 32'h100);

        // 4: misaligned redirect, then recovery
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        chk("t4.err", {31'b0, misalign_err}, 32'd1);
        chk("t4.valid", {31'b0, out_valid}, 32'd0);
        tick(); tick();
        chk("t4.err_hold", {31'b0, misalign_err}, 32'd1);
        chk("t4.valid_hold", {31'b0, out_valid}, 32'd0);
        chk("t4.addr_hold", instr_addr, 32'h102);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("t4.err_clr", {31'b0, misalign_err}, 32'd0);
        chk("t4.bubble", {31'b0, out_valid}, 32'd0);
        tick();
        chk_head("t4.target", 32'h200);

        // fetch_en low drains FIFO and holds pc
        fetch_en = 1'b0;
        tick();
        chk("fe.drained", {31'b0, out_valid}, 32'd0);
        tick();
        chk("fe.addr_hold", instr_addr, 32'h204);
        fetch_en = 1'b1;
        tick();
        chk("fe.restart", {31'b0, out_valid}, 32'd0);
        tick();
        chk_head("fe.resume", 32'h204);

        // 6: async reset between edges, streaming and in ERR
        #2 rst_n = 1'b0;
        #1;
        chk("t6.valid_drop", {31'b0, out_valid}, 32'd0);
        chk("t6.addr", instr_addr, 32'h0);
        rst_n = 1'b1;
        tick(); tick();
        chk_head("t6.restart", 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h3;
        tick();
        redirect_valid = 1'b0;
        chk("t6.err_set", {31'b0, misalign_err}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6.err_drop", {31'b0, misalign_err}, 32'd0);
        rst_n = 1'b1;
        tick(); tick();
        chk_head("t6.restart2", 32'h0);

        // 5: PC wrap on the second instance
        rst_n_w = 1'b1; fetch_en_w = 1'b1;
        tick(); tick();
        chk("t5.pc0", out_pc_w, 32'hFFFF_FFF8);
        chk("t5.in0", out_instr_w, 32'h4FFF_FFFE);
        tick();
        chk("t5.pc1", out_pc_w, 32'hFFFF_FFFC);
        tick();
        chk("t5.pc2", out_pc_w, 32'h0000_0000);
        chk("t5.in2", out_instr_w, 32'h1000_0000);
        chk("t5.valid", {31'b0, out_valid_w}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
